series_job_dispatcher: RTL and testbench
========================================

// Module: series_job_dispatcher
// PURPOSE
// - Initiator side of the start/ready handshake used by the 16-step series-evaluation controller/datapath.
// - Buffers incoming operands in a FIFO and launches one engine job per operand.
// - Holds the operand stable for the engine's load, waits for completion and captures the result.
// - Presents results on a valid/ready output port, in input order.
// PARAMETERS
// - DW       16  operand/result width
// - DEPTH    8   input job FIFO depth (power of 2, >=2)
// - ACK_MAX  4   cycles allowed from eng_start rise to eng_ready fall
// - DONE_MAX 128 cycles allowed from eng_start fall to eng_ready rise
// PORTS
// - clk         in   1   rising-edge clock, single clock domain
// - rst         in   1   synchronous, active-high reset
// - in_valid    in   1   operand offered
// - in_data     in   DW  operand
// - in_ready    out  1   FIFO not full; transfer when in_valid&in_ready
// - eng_start   out  1   engine start request (level)
// - eng_x       out  DW  operand to engine, registered
// - eng_ready   in   1   engine idle/done (1 = idle, result valid)
// - eng_result  in   DW  engine result, valid while eng_ready=1 after a job
// - out_valid   out  1   result available
// - out_data    out  DW  result
// - out_ready   in   1   consumer accepts; transfer when out_valid&out_ready
// - busy        out  1   FSM not in IDLE or FIFO non-empty
// - timeout_err out  1   sticky; set on ACK or DONE timeout, cleared only by rst
// BEHAVIOUR
// - Reset values: eng_start=0, eng_x=0, out_valid=0, out_data=0, timeout_err=0, busy=0.
// - Reset also empties the FIFO. in_ready=1 the cycle after reset.
// - Reset mid-job aborts it; the engine must be reset alongside.
// - FSM states:
//   - IDLE: if FIFO non-empty and eng_ready=1, pop the head into eng_x and go to ISSUE.
//   - ISSUE: eng_start=1. On eng_ready=0, go to RELEASE. After ACK_MAX cycles without it, set timeout_err and go to IDLE (job dropped).
//   - RELEASE: eng_start=0 for exactly 1 cycle (engine latches x here). Go to RUN.
//   - RUN: eng_start=0, eng_x held. On eng_ready=1, go to CAPT. After DONE_MAX cycles, set timeout_err and go to IDLE.
//   - CAPT: if out_valid=0 or out_ready=1, load out_data<=eng_result, set out_valid=1, go to IDLE. Otherwise stall in CAPT (eng_start stays 0).
// - eng_x changes only in the IDLE->ISSUE transition; it is stable from ISSUE through CAPT.
// - Output register: out_valid clears on handshake unless CAPT reloads it in the same cycle.
// - Simultaneous handshake and CAPT load gives a back-to-back transfer with no bubble.
// - FIFO:
//   - Push and pop in the same cycle when full is allowed: count unchanged, in_ready stays 0 that cycle.
//   - Pop when empty never occurs. Pointers wrap mod DEPTH.
// - Minimum job latency, measured from the IDLE pop to out_valid=1: 3 cycles plus the engine run time.
// - Timeout counter is log2(max(ACK_MAX,DONE_MAX))+1 bits and clears on every state change.
// STRUCTURE
// - Package series_pkg: state enum {IDLE,ISSUE,RELEASE,RUN,CAPT}, default DW, ACK_MAX, DONE_MAX constants.
// - Sub-module sync_fifo #(DW,DEPTH): push/pop, full/empty, count; one instance.
// - Top level holds the FSM, timeout counter and output register.
// - Bench engine model: ready=1 idle; start -> ready=0; latch x the cycle after start falls; ready=1 after N cycles with result=x+1.
// TESTING
// - Single job: push 0x0010, engine N=80 -> one start pulse, eng_x=0x0010 held through RUN, out_data=0x0011 exactly once.
// - Burst: push 8 ops 1..8 with out_ready=1 -> in_ready=0 after 8 pushes with none popped, outputs 2..9 in order, no dropped jobs.
// - Backpressure: out_ready=0 while 2 jobs complete -> first held in out_data, FSM stalls in CAPT; release -> both delivered in order.
// - ACK timeout: eng_ready stuck 1 -> timeout_err=1 after ACK_MAX cycles; the next job still proceeds once the engine responds.
// - DONE timeout: eng_ready stays 0 for 200 cycles -> timeout_err=1 at DONE_MAX, FSM back to IDLE, job dropped.
// - Reset mid-RUN: assert rst 1 cycle -> all outputs at reset values next cycle, FIFO empty, busy=0.

Source files
------------

// File: rtl/series_pkg.sv
// rtl/series_pkg.sv - shared types and default constants for the series job dispatcher
package series_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        RELEASE = 3'd2,
        RUN     = 3'd3,
        CAPT    = 3'd4
    } state_t;

    localparam int DEF_DW       = 16;
    localparam int DEF_DEPTH    = 8;
    localparam int DEF_ACK_MAX  = 4;
    localparam int DEF_DONE_MAX = 128;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock show-ahead FIFO with full/empty/count
module sync_fifo #(
    parameter int DW    = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DW-1:0]              push_data,
    input  logic                       pop,
    output logic [DW-1:0]              pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          do_push;
    logic          do_pop;

    // A push into a full FIFO is only taken when a pop frees the head slot in the same cycle
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign full     = (cnt == FULL_CNT);
    assign empty    = (cnt == '0);
    assign count    = cnt;
    assign pop_data = mem[rd_ptr];

    // Storage array; no reset needed since reads are gated by the count
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/series_job_dispatcher.sv
// rtl/series_job_dispatcher.sv - queues operands and runs them one at a time through the series engine
module series_job_dispatcher
    import series_pkg::*;
#(
    parameter int DW       = DEF_DW,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ACK_MAX  = DEF_ACK_MAX,
    parameter int DONE_MAX = DEF_DONE_MAX
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          eng_start,
    output logic [DW-1:0] eng_x,
    input  logic          eng_ready,
    input  logic [DW-1:0] eng_result,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    input  logic          out_ready,
    output logic          busy,
    output logic          timeout_err
);

    localparam int TMAX = (ACK_MAX > DONE_MAX) ? ACK_MAX : DONE_MAX;
    localparam int TW   = $clog2(TMAX) + 1;
    localparam logic [TW-1:0] ACK_LAST  = TW'(ACK_MAX - 1);
    localparam logic [TW-1:0] DONE_LAST = TW'(DONE_MAX - 1);

    state_t                  state;
    state_t                  state_nx;
    logic [TW-1:0]           tcnt;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [DW-1:0]           fifo_head;
    logic [$clog2(DEPTH):0]  fifo_count;
    logic                    push;
    logic                    pop;
    logic                    load_out;
    logic                    to_set;

    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;
    assign busy     = (state != IDLE) || (fifo_count != '0);

    sync_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Handshake sequencing: launch, wait for ack, release start for the load cycle, wait for done, capture
    always_comb begin
        state_nx  = state;
        pop       = 1'b0;
        load_out  = 1'b0;
        to_set    = 1'b0;
        eng_start = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && eng_ready) begin
                    pop      = 1'b1;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                eng_start = 1'b1;
                if (!eng_ready) begin
                    state_nx = RELEASE;
                end else if (tcnt == ACK_LAST) begin
                    to_set   = 1'b1;
                    state_nx = IDLE;
                end
            end
            RELEASE: begin
                state_nx = RUN;
            end
            RUN: begin
                if (eng_ready) begin
                    state_nx = CAPT;
                end else if (tcnt == DONE_LAST) begin
                    to_set   = 1'b1;
                    state_nx = IDLE;
                end
            end
            CAPT: begin
                if (!out_valid || out_ready) begin
                    load_out = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Watchdog counts only while waiting on the engine and restarts on every state change
    always_ff @(posedge clk) begin
        if (rst || (state_nx != state)) begin
            tcnt <= '0;
        end else if ((state == ISSUE) || (state == RUN)) begin
            tcnt <= tcnt + 1'b1;
        end
    end

    // Operand hold, result register and sticky timeout flag
    always_ff @(posedge clk) begin
        if (rst) begin
            eng_x       <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (pop) begin
                eng_x <= fifo_head;
            end
            if (load_out) begin
                out_data  <= eng_result;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (to_set) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_series_job_dispatcher.sv
// tb/tb_series_job_dispatcher.sv - self-checking bench with engine model and result-order reference
module tb_series_job_dispatcher;

    localparam int DW       = 16;
    localparam int DEPTH    = 8;
    localparam int ACK_MAX  = 4;
    localparam int DONE_MAX = 128;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          eng_start;
    logic [DW-1:0] eng_x;
    logic          eng_ready;
    logic [DW-1:0] eng_result;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          busy;
    logic          timeout_err;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_q[$];
    int  outs_seen   = 0;
    int  start_rises = 0;
    bit  start_prev  = 0;
    bit  drop_next   = 0;

    bit  stuck_idle = 0;
    bit  stuck_busy = 0;
    bit  force_busy = 0;
    int  eng_n      = 10;

    logic          eng_rdy_r;
    logic [DW-1:0] eng_res_r;
    logic [DW-1:0] eng_lx;
    int            eng_phase;
    int            eng_cnt;

    series_job_dispatcher #(
        .DW       (DW),
        .DEPTH    (DEPTH),
        .ACK_MAX  (ACK_MAX),
        .DONE_MAX (DONE_MAX)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .eng_start   (eng_start),
        .eng_x       (eng_x),
        .eng_ready   (eng_ready),
        .eng_result  (eng_result),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign eng_ready  = eng_rdy_r && !force_busy;
    assign eng_result = eng_res_r;

    // Engine model: drop ready on start, latch x once start falls, finish N cycles later with x+1
    always @(posedge clk) begin
        if (rst) begin
            eng_rdy_r <= 1'b1;
            eng_res_r <= '0;
            eng_lx    <= '0;
            eng_phase <= 0;
            eng_cnt   <= 0;
        end else begin
            case (eng_phase)
                0: if (eng_start && eng_rdy_r && !stuck_idle) begin
                    eng_rdy_r <= 1'b0;
                    eng_phase <= 1;
                end
                1: if (!eng_start) begin
                    eng_lx    <= eng_x;
                    eng_cnt   <= eng_n;
                    eng_phase <= 2;
                end
                default: if (!stuck_busy) begin
                    if (eng_cnt <= 1) begin
                        eng_rdy_r <= 1'b1;
                        eng_res_r <= eng_lx + 16'd1;
                        eng_phase <= 0;
                    end else begin
                        eng_cnt <= eng_cnt - 1;
                    end
                end
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // One clock: score handshakes due at the coming edge, then advance to the next negedge
    task automatic tick();
        bit ixf;
        bit oxf;
        ixf = in_valid && in_ready && !rst;
        oxf = out_valid && out_ready && !rst;
        if (oxf) begin
            outs_seen++;
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL spurious_out: observed %0h with nothing expected", out_data);
            end
            if (exp_q.size() != 0) check("out_data_order", out_data, exp_q.pop_front());
        end
        if (ixf) begin
            if (drop_next) drop_next = 0;
            else exp_q.push_back(in_data + 16'd1);
        end
        @(posedge clk);
        @(negedge clk);
        if (eng_start && !start_prev) start_rises++;
        start_prev = eng_start;
        if (eng_phase == 2 && !rst) check("eng_x_held", eng_x, eng_lx);
    endtask

    task automatic push_op(input logic [DW-1:0] d);
        int k;
        k = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && k < 200) begin
            tick();
            k++;
        end
        check("push_accept", k < 200, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int bound);
        int k;
        k = 0;
        while (!(exp_q.size() == 0 && !busy && !out_valid) && k < bound) begin
            tick();
            k++;
        end
        check({tag, "_drain"}, k < bound, 1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_eng_start"}, eng_start, 0);
        check({tag, "_eng_x"}, eng_x, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_timeout_err"}, timeout_err, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_in_ready"}, in_ready, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        drop_next = 0;
    endtask

    initial begin
        int k;
        int base_outs;
        int base_starts;
        int sent;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;
        check_reset_state("reset");

        // Single job with a long engine run
        out_ready = 1'b1; eng_n = 80;
        base_outs = outs_seen; base_starts = start_rises;
        push_op(16'h0010);
        wait_drain("single", 400);
        check("single_starts", start_rises - base_starts, 1);
        check("single_outs", outs_seen - base_outs, 1);
        check("single_last_data", out_data, 16'h0011);

        // Burst fills the FIFO while the engine is held busy
        force_busy = 1; eng_n = 3;
        base_outs = outs_seen; base_starts = start_rises;
        for (int i = 1; i <= 8; i++) push_op(16'(i));
        check("burst_full_in_ready", in_ready, 0);
        check("burst_busy", busy, 1);
        check("burst_none_popped", start_rises - base_starts, 0);
        force_busy = 0;
        wait_drain("burst", 600);
        check("burst_outs", outs_seen - base_outs, 8);
        check("burst_starts", start_rises - base_starts, 8);

        // Backpressure: two jobs complete while the consumer stalls
        out_ready = 1'b0; eng_n = 5;
        base_outs = outs_seen; base_starts = start_rises;
        push_op(16'h0100);
        push_op(16'h0200);
        repeat (60) tick();
        check("bp_out_valid", out_valid, 1);
        check("bp_out_data", out_data, 16'h0101);
        check("bp_busy_stalled", busy, 1);
        check("bp_eng_start_low", eng_start, 0);
        check("bp_starts", start_rises - base_starts, 2);
        repeat (10) tick();
        check("bp_out_data_held", out_data, 16'h0101);
        out_ready = 1'b1;
        wait_drain("bp", 200);
        check("bp_outs", outs_seen - base_outs, 2);

        // Randomized traffic against the in-order reference queue
        base_outs = outs_seen;
        sent = 0; k = 0;
        while (sent < 40 && k < 5000) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            eng_n     = $urandom_range(1, 20);
            if (in_valid && in_ready) sent++;
            tick();
            k++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("rand_sent", sent, 40);
        wait_drain("rand", 3000);
        check("rand_outs", outs_seen - base_outs, 40);

        // ACK timeout: engine never acknowledges start
        stuck_idle = 1; drop_next = 1; eng_n = 4;
        base_outs = outs_seen;
        push_op(16'h0aaa);
        k = 0;
        while (!eng_start && k < 20) begin tick(); k++; end
        check("ack_start_seen", eng_start, 1);
        k = 0;
        while (!timeout_err && k < 20) begin tick(); k++; end
        check("ack_timeout_cycles", k, ACK_MAX);
        check("ack_timeout_err", timeout_err, 1);
        check("ack_start_dropped", eng_start, 0);
        check("ack_busy", busy, 0);
        stuck_idle = 0;
        push_op(16'h0bbb);
        wait_drain("ack_next", 200);
        check("ack_next_outs", outs_seen - base_outs, 1);
        check("ack_next_data", out_data, 16'h0bbc);
        check("ack_sticky", timeout_err, 1);

        do_reset();
        check("rst_clears_err", timeout_err, 0);

        // DONE timeout: engine accepts but never finishes
        stuck_busy = 1; drop_next = 1; eng_n = 10;
        base_outs = outs_seen;
        push_op(16'h0ccc);
        k = 0;
        while (!eng_start && k < 20) begin tick(); k++; end
        k = 0;
        while (eng_start && k < 20) begin tick(); k++; end
        check("done_start_fell", eng_start, 0);
        k = 0;
        while (!timeout_err && k < 200) begin tick(); k++; end
        check("done_timeout_cycles", k, DONE_MAX + 1);
        check("done_timeout_err", timeout_err, 1);
        check("done_busy", busy, 0);
        check("done_outs", outs_seen - base_outs, 0);
        stuck_busy = 0;
        do_reset();

        // Reset in the middle of a running job
        out_ready = 1'b1; eng_n = 3;
        push_op(16'h0050);
        wait_drain("prerst", 200);
        check("prerst_data", out_data, 16'h0051);
        eng_n = 50;
        base_outs = outs_seen;
        push_op(16'h0123);
        k = 0;
        while (eng_phase != 2 && k < 50) begin tick(); k++; end
        check("midrun_reached", eng_phase, 2);
        repeat (5) tick();
        do_reset();
        check_reset_state("midrun");
        repeat (100) tick();
        check("midrun_no_output", outs_seen - base_outs, 0);
        check("midrun_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
